// File: rtl/pixel_packer_pkg.sv
// Shared widths and state encoding for the 12-bit pixel to 16-bit word packer.
package pixel_packer_pkg;

   localparam int unsigned PIX_W   = 12;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned ACC_W   = 28;
   // Fill count spans 0..27, five bits suffice.
   localparam int unsigned NBITS_W = 5;

   typedef enum logic [1:0] {
      RUN,
      FLUSH,
      WAIT
   } state_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs a stream of 12-bit pixels LSB-first into 16-bit words for a bank FIFO
// write port. The last pixel of a frame triggers a flush of the residue as a
// zero-padded word, followed by a frame_done pulse carrying the word count.
module pixel_packer
   import pixel_packer_pkg::*;
#(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               pix_valid,
   input  logic [PIX_W-1:0]   pix_data,
   input  logic               pix_last,
   output logic               pix_ready,
   output logic               w_trigger,
   output logic [WORD_W-1:0]  w_data,
   input  logic               w_done,
   output logic               frame_done,
   output logic [COUNT_W-1:0] frame_words
);

   state_t               state_q, state_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [NBITS_W-1:0]   nbits_q, nbits_d;
   logic                 trig_q, trig_d;
   logic [WORD_W-1:0]    data_q, data_d;
   logic                 run_en_q;
   logic                 done_q, done_d;
   logic [COUNT_W-1:0]   cnt_q, cnt_d;
   logic [COUNT_W-1:0]   fwords_q, fwords_d;

   logic                 slot_free;
   logic                 word_acc;
   logic                 full_word;
   logic                 xfer;
   logic                 move_word;
   logic                 pad_word;
   logic                 load;
   logic                 finish;
   logic [COUNT_W-1:0]   cnt_inc;

   // Output slot can take a new word when empty or being drained this cycle.
   assign slot_free = !trig_q || w_done;
   assign word_acc  = trig_q && w_done;
   assign full_word = nbits_q >= NBITS_W'(WORD_W);

   // Handshake and word-move decode; accept and move never coincide since
   // one needs nbits<=15 and the other nbits>=16.
   always_comb begin
      pix_ready = run_en_q && (state_q == RUN) && !full_word;
      xfer      = pix_valid && pix_ready;
      move_word = full_word && slot_free;
      pad_word  = (state_q == FLUSH) && !full_word && (nbits_q != '0) && slot_free;
      load      = move_word || pad_word;
      finish    = (state_q == WAIT) && slot_free;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (xfer && pix_last) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (nbits_q == '0) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (finish) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // Datapath and output next-state: accumulator, word slot, frame counters.
   always_comb begin
      acc_d    = acc_q;
      nbits_d  = nbits_q;
      data_d   = data_q;
      trig_d   = trig_q;
      cnt_d    = cnt_q;
      fwords_d = fwords_q;
      done_d   = finish;

      if (xfer) begin
         acc_d   = acc_q | (ACC_W'(pix_data) << nbits_q);
         nbits_d = nbits_q + NBITS_W'(PIX_W);
      end else if (move_word) begin
         acc_d   = acc_q >> WORD_W;
         nbits_d = nbits_q - NBITS_W'(WORD_W);
      end else if (pad_word) begin
         // Bits above nbits are already zero, so the low word is the padded residue.
         acc_d   = '0;
         nbits_d = '0;
      end

      if (load) begin
         data_d = acc_q[WORD_W-1:0];
         trig_d = 1'b1;
      end else if (w_done) begin
         trig_d = 1'b0;
      end

      cnt_inc = (word_acc && (cnt_q != '1)) ? cnt_q + COUNT_W'(1) : cnt_q;
      if (finish) begin
         // The final word's acceptance may land on the same edge as the finish.
         fwords_d = cnt_inc;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_inc;
      end
   end

   // Datapath registers; run_en holds pix_ready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         acc_q    <= '0;
         nbits_q  <= '0;
         trig_q   <= 1'b0;
         data_q   <= '0;
         run_en_q <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         fwords_q <= '0;
      end else begin
         acc_q    <= acc_d;
         nbits_q  <= nbits_d;
         trig_q   <= trig_d;
         data_q   <= data_d;
         run_en_q <= 1'b1;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         fwords_q <= fwords_d;
      end
   end

   assign w_trigger   = trig_q;
   assign w_data      = data_q;
   assign frame_done  = done_q;
   assign frame_words = fwords_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Directed bench for pixel_packer: reset values, small frames with known words,
// back-pressure hold, mid-frame reset and a long random-back-pressure frame.
module tb_pixel_packer;

   logic        clk;
   logic        rst_;
   logic        pix_valid;
   logic [11:0] pix_data;
   logic        pix_last;
   logic        pix_ready;
   logic        w_trigger;
   logic [15:0] w_data;
   logic        w_done;
   logic        frame_done;
   logic [15:0] frame_words;

   int          n_pass;
   int          n_checks;
   int          w_mode;     // 0: w_done high, 1: w_done low, 2: random
   int          fd_cnt;
   int          exp_fd;
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   logic [11:0] pix_mem[4096];

   pixel_packer #(
      .COUNT_W (16)
   ) dut (
      .clk         (clk),
      .rst_        (rst_),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .pix_last    (pix_last),
      .pix_ready   (pix_ready),
      .w_trigger   (w_trigger),
      .w_data      (w_data),
      .w_done      (w_done),
      .frame_done  (frame_done),
      .frame_words (frame_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream acceptance, changed mid-way through the low phase.
   initial w_done = 1'b0;
   always @(negedge clk) begin
      #1;
      case (w_mode)
         0:       w_done = 1'b1;
         1:       w_done = 1'b0;
         default: w_done = ($urandom_range(3) != 0);
      endcase
   end

   // Collect accepted words and frame_done pulses.
   initial fd_cnt = 0;
   always @(posedge clk) begin
      if (rst_ && w_trigger && w_done) got_q.push_back(w_data);
      if (frame_done) fd_cnt++;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected finish before 900us");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic timeout_fail(input string tag);
      n_checks++;
      $error("FAIL %s: got timeout expected event", tag);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_pix(input logic [11:0] d, input logic l);
      int t;
      t = 0;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_last  = l;
      while (!pix_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!pix_ready) timeout_fail("accept_timeout");
      @(negedge clk);
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic wait_frame(input int limit);
      int t;
      t = 0;
      exp_fd++;
      while (fd_cnt < exp_fd && t < limit) begin
         @(negedge clk);
         t++;
      end
      if (fd_cnt < exp_fd) timeout_fail("frame_done_timeout");
   endtask

   task automatic check_words(input string tag);
      check({tag, "_nwords"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      end
   endtask

   initial begin
      logic [11:0] p;
      logic [15:0] w;
      int          j;
      n_pass    = 0;
      n_checks  = 0;
      exp_fd    = 0;
      w_mode    = 0;
      rst_      = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_last  = 1'b0;

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_pix_ready", pix_ready, 0);
      check("rst_w_trigger", w_trigger, 0);
      check("rst_w_data", w_data, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_words", frame_words, 0);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_after_reset", pix_ready, 1);

      // Four pixels into three words.
      got_q.delete();
      send_pix(12'hABC, 1'b0);
      send_pix(12'h123, 1'b0);
      send_pix(12'h456, 1'b0);
      send_pix(12'h789, 1'b1);
      wait_frame(100);
      exp_q = '{16'h3ABC, 16'h5612, 16'h7894};
      check_words("four_pix");
      check("four_pix_frame_words", frame_words, 3);
      check("frame_done_one_cycle", frame_done, 0);

      // Two pixels: one full word then a zero-padded residue; word latency.
      got_q.delete();
      send_pix(12'h001, 1'b0);
      send_pix(12'h002, 1'b1);
      check("latency_edge_n", w_trigger, 0);
      @(negedge clk);
      check("latency_edge_n1", w_trigger, 1);
      check("latency_data", w_data, 16'h2001);
      wait_frame(100);
      exp_q = '{16'h2001, 16'h0000};
      check_words("two_pix");
      check("two_pix_frame_words", frame_words, 2);

      // Single pixel frame.
      got_q.delete();
      send_pix(12'hFFF, 1'b1);
      wait_frame(100);
      exp_q = '{16'h0FFF};
      check_words("one_pix");
      check("one_pix_frame_words", frame_words, 1);

      // Back-pressure: w_done low for 20 cycles with a word pending.
      got_q.delete();
      w_mode = 1;
      send_pix(12'hABC, 1'b0);
      send_pix(12'h123, 1'b0);
      send_pix(12'h456, 1'b0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("hold_trig_%0d", i), w_trigger, 1);
         check($sformatf("hold_data_%0d", i), w_data, 16'h3ABC);
         check($sformatf("hold_ready_%0d", i), pix_ready, 0);
      end
      w_mode = 0;
      send_pix(12'h789, 1'b1);
      wait_frame(100);
      exp_q = '{16'h3ABC, 16'h5612, 16'h7894};
      check_words("hold");
      check("hold_frame_words", frame_words, 3);

      // Reset mid-frame with a word pending in the slot.
      got_q.delete();
      send_pix(12'hABC, 1'b0);
      send_pix(12'h123, 1'b0);
      @(negedge clk);
      check("pre_rst_trig", w_trigger, 1);
      #2;
      rst_ = 1'b0;
      #1;
      check("midrst_w_trigger", w_trigger, 0);
      check("midrst_w_data", w_data, 0);
      check("midrst_pix_ready", pix_ready, 0);
      check("midrst_frame_words", frame_words, 0);
      @(negedge clk);
      rst_ = 1'b1;
      repeat (2) @(negedge clk);
      send_pix(12'hABC, 1'b0);
      send_pix(12'h123, 1'b0);
      send_pix(12'h456, 1'b0);
      send_pix(12'h789, 1'b1);
      wait_frame(100);
      exp_q = '{16'h3ABC, 16'h5612, 16'h7894};
      check_words("after_rst");
      check("after_rst_frame_words", frame_words, 3);

      // Long frame with random acceptance gaps.
      got_q.delete();
      exp_q.delete();
      w_mode = 2;
      for (int i = 0; i < 4096; i++) pix_mem[i] = 12'($urandom_range(4095));
      for (int i = 0; i < 4096; i++) send_pix(pix_mem[i], (i == 4095));
      wait_frame(2000);
      for (int k = 0; k < 3072; k++) begin
         for (int b = 0; b < 16; b++) begin
            j    = 16 * k + b;
            p    = pix_mem[j / 12];
            w[b] = p[j % 12];
         end
         exp_q.push_back(w);
      end
      check_words("bulk");
      check("bulk_frame_words", frame_words, 3072);

      w_mode = 0;
      repeat (3) @(negedge clk);
      check("frame_done_pulses", fd_cnt, exp_fd);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
